// File: rtl/add_comp_nat.sv
// add_comp_nat: registered N-bit natural adder (x + y + c_in) feeding an
// (N+1)-bit natural comparator against b. One cycle of latency; the sum and
// the compare flags are registered on the same edge.
//
// Typical uses:
//   - |x|+|y| against a limit, with b as the limit.
//   - Two's-complement negation: x = ~v, y = 0, c_in = 1 gives s = -v mod 2^N.
//
// Ports:
//   clock      in   1    all state updates on posedge
//   reset      in   1    synchronous, active-high; wins over in_valid
//   in_valid   in   1    operands valid, captured on posedge
//   x, y       in   N    adder operands (natural)
//   c_in       in   1    adder carry-in
//   b          in   N+1  comparator reference (natural)
//   out_valid  out  1    one-cycle pulse per accepted operand set
//   s          out  N    sum bits [N-1:0]
//   c_out      out  1    sum bit N
//   min        out  1    {c_out,s} <  b
//   eq         out  1    {c_out,s} == b
//   ovf        out  1    only with ADD_OVF_EN: two's-complement overflow of s
//
// Build option:
//   ADD_OVF_EN  when defined, adds the registered ovf output.
module add_comp_nat #(
    parameter int N = 8
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         in_valid,
    input  logic [N-1:0] x,
    input  logic [N-1:0] y,
    input  logic         c_in,
    input  logic [N:0]   b,
    output logic         out_valid,
    output logic [N-1:0] s,
    output logic         c_out,
    output logic         min,
    output logic         eq
`ifdef ADD_OVF_EN
   ,output logic         ovf
`endif
);

    // Full N+1 bit sum: the largest possible value 2^(N+1)-1 still fits,
    // so the carry is never lost.
    logic [N:0] sum;
    assign sum = {1'b0, x} + {1'b0, y} + {{N{1'b0}}, c_in};

`ifdef ADD_OVF_EN
    // Carry into bit N-1 is recovered from the sum bit and the operand bits;
    // signed overflow is that carry XOR the carry out of bit N-1.
    logic ovf_nxt;
    assign ovf_nxt = (sum[N-1] ^ x[N-1] ^ y[N-1]) ^ sum[N];
`endif

    always_ff @(posedge clock) begin
        if (reset) begin
            out_valid <= 1'b0;
            s         <= '0;
            c_out     <= 1'b0;
            min       <= 1'b0;
            eq        <= 1'b0;
`ifdef ADD_OVF_EN
            ovf       <= 1'b0;
`endif
        end else begin
            // Results hold while idle; only the valid flag pulses.
            out_valid <= in_valid;
            if (in_valid) begin
                s     <= sum[N-1:0];
                c_out <= sum[N];
                min   <= (sum <  b);
                eq    <= (sum == b);
`ifdef ADD_OVF_EN
                ovf   <= ovf_nxt;
`endif
            end
        end
    end

endmodule

// File: tb/tb_add_comp_nat.sv
module tb_add_comp_nat;

    typedef struct packed {
        logic [7:0] s;
        logic       c;
        logic       mn;
        logic       eq;
        logic       ov;
    } res_t;

    logic       clock;
    logic       reset;
    logic       in_valid;
    logic [7:0] x;
    logic [7:0] y;
    logic       c_in;
    logic [8:0] b;
    logic       out_valid;
    logic [7:0] s;
    logic       c_out;
    logic       min;
    logic       eq;
`ifdef ADD_OVF_EN
    logic       ovf;
`endif

    add_comp_nat #(.N(8)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .x         (x),
        .y         (y),
        .c_in      (c_in),
        .b         (b),
        .out_valid (out_valid),
        .s         (s),
        .c_out     (c_out),
        .min       (min),
        .eq        (eq)
`ifdef ADD_OVF_EN
       ,.ovf       (ovf)
`endif
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int   nchk = 0;
    int   nerr = 0;
    res_t q[$];
    res_t last = '0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Drive one cycle of stimulus, push the expected result, then check the
    // registered outputs 1 time unit after the capturing edge.
    task automatic cyc(input logic rst, input logic v, input logic [7:0] xx,
                       input logic [7:0] yy, input logic ci, input logic [8:0] bb);
        res_t e;
        int   sm;
        int   sg;
        reset    = rst;
        in_valid = v;
        x        = xx;
        y        = yy;
        c_in     = ci;
        b        = bb;
        if (v && !rst) begin
            sm   = int'(xx) + int'(yy) + int'(ci);
            sg   = int'($signed(xx)) + int'($signed(yy)) + int'(ci);
            e.s  = sm[7:0];
            e.c  = sm[8];
            e.mn = (sm <  int'(bb));
            e.eq = (sm == int'(bb));
            e.ov = (sg > 127) || (sg < -128);
            q.push_back(e);
        end
        @(posedge clock);
        #1;
        if (rst) begin
            last = '0;
        end else if (v) begin
            if (q.size() == 0) chk("sb_underflow", 1, 0);
            else last = q.pop_front();
        end
        chk("out_valid", {31'b0, out_valid}, {31'b0, (v && !rst)});
        chk("s",     {24'b0, s},     {24'b0, last.s});
        chk("c_out", {31'b0, c_out}, {31'b0, last.c});
        chk("min",   {31'b0, min},   {31'b0, last.mn});
        chk("eq",    {31'b0, eq},    {31'b0, last.eq});
`ifdef ADD_OVF_EN
        chk("ovf",   {31'b0, ovf},   {31'b0, last.ov});
`endif
    endtask

    initial begin
        reset = 1'b1; in_valid = 1'b0; x = '0; y = '0; c_in = 1'b0; b = '0;

        // Reset held two cycles with in_valid asserted: nothing accepted.
        cyc(1, 1, 8'd1, 8'd2, 0, 9'd3);
        cyc(1, 1, 8'd1, 8'd2, 0, 9'd3);

        // Directed cases.
        cyc(0, 1, 8'd40,  8'd24, 0, 9'd64);   // equal: 64
        cyc(0, 1, 8'd20,  8'd11, 0, 9'd32);   // below: 31
        cyc(0, 1, 8'd200, 8'd100, 0, 9'd64);  // above: 300
        cyc(0, 1, 8'hFF,  8'h00, 1, 9'd0);    // negate 0
        cyc(0, 1, 8'h7F,  8'h00, 1, 9'd0);    // negate 0x80
        cyc(0, 1, 8'd255, 8'd255, 1, 9'd511); // carry extreme
        cyc(0, 0, 8'd3,   8'd4,  0, 9'd0);    // hold
        cyc(0, 0, 8'd9,   8'd9,  1, 9'd1);    // hold again
        cyc(0, 1, 8'd127, 8'd1,  0, 9'd128);  // signed overflow
        cyc(0, 1, 8'd255, 8'd1,  0, 9'd256);  // wrap, no signed overflow
        cyc(0, 1, 8'd0,   8'd0,  0, 9'd0);    // zero equals zero
        cyc(0, 1, 8'd0,   8'd0,  0, 9'd1);    // zero below one

        // Reset in the middle of traffic discards the operand.
        cyc(1, 1, 8'd10, 8'd10, 1, 9'd21);
        cyc(0, 1, 8'd10, 8'd10, 1, 9'd21);

        // Random traffic with idle gaps and occasional resets.
        for (int i = 0; i < 60; i++) begin
            logic [7:0] rx;
            logic [7:0] ry;
            logic [8:0] rb;
            logic       rc;
            rx = 8'($urandom);
            ry = 8'($urandom);
            rc = 1'($urandom);
            // Bias b toward the actual sum so eq gets exercised.
            rb = ($urandom_range(0, 2) == 0) ? 9'(int'(rx) + int'(ry) + int'(rc)) : 9'($urandom);
            cyc(($urandom_range(0, 15) == 0), ($urandom_range(0, 3) != 0), rx, ry, rc, rb);
        end

        chk("sb_drained", q.size(), 0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
